// File: rtl/regfile_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_writeback_arbiter
//
// Write-side front end of the 32x32 register file. It merges two producers
// onto the single register-file write port:
//   - the primary pipeline result (ALU/load). It has top priority and no
//     backpressure.
//   - the long-latency unit (mul/div). It uses a valid/ready handshake, and
//     its results wait in a small FIFO while the primary path owns the port.
//
// Writes to r0 are discarded. Queued results are squashed (their valid bit is
// cleared) when a newer primary write targets the same register, so a stale
// long-latency value can never overwrite a newer primary value. The hazard
// port reports whether a register still has a live queued write.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   pri_valid/addr/data        primary result (always accepted)
//   lat_valid/ready/addr/data  long-latency result handshake
//   rf_we/waddr/wdata          registered register-file write port
//   chk_addr, chk_pending      hazard query: live queued write to chk_addr
//   q_count                    current queue occupancy
// -----------------------------------------------------------------------------
module regfile_writeback_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     pri_valid,
   input  logic [ADDR_W-1:0]        pri_addr,
   input  logic [DATA_W-1:0]        pri_data,
   input  logic                     lat_valid,
   output logic                     lat_ready,
   input  logic [ADDR_W-1:0]        lat_addr,
   input  logic [DATA_W-1:0]        lat_data,
   output logic                     rf_we,
   output logic [ADDR_W-1:0]        rf_waddr,
   output logic [DATA_W-1:0]        rf_wdata,
   input  logic [ADDR_W-1:0]        chk_addr,
   output logic                     chk_pending,
   output logic [$clog2(DEPTH):0]   q_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   // queue storage
   logic [DEPTH-1:0][ADDR_W-1:0] r_q_addr;
   logic [DEPTH-1:0][DATA_W-1:0] r_q_data;
   logic [DEPTH-1:0]             r_q_vld;
   logic [PTR_W-1:0]             r_head;
   logic [PTR_W-1:0]             r_tail;
   logic [CNT_W-1:0]             r_count;

   // registered write port
   logic                         r_rf_we;
   logic [ADDR_W-1:0]            r_rf_waddr;
   logic [DATA_W-1:0]            r_rf_wdata;

   logic                         w_pri_go;
   logic                         w_lat_acc;
   logic                         w_lat_nz;
   logic                         w_empty;
   logic                         w_full;
   logic                         w_pop;
   logic                         w_bypass;
   logic                         w_push;
   logic                         w_head_vld;
   logic                         w_sel_we;
   logic                         w_sel_upd;
   logic [ADDR_W-1:0]            w_sel_addr;
   logic [DATA_W-1:0]            w_sel_data;
   logic [DEPTH-1:0]             w_squash;
   logic [DEPTH-1:0]             w_hit;

   // ---------------------------------------------------------------------------
   // Handshake and control decode
   // ---------------------------------------------------------------------------
   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == FULL_CNT);
   // Ready comes from registered occupancy only. A pop in this same cycle
   // does not open a slot until the next cycle, which keeps ready off the
   // pri_valid timing path.
   assign lat_ready  = rst_n && !w_full;

   assign w_pri_go   = pri_valid && (pri_addr != '0);
   assign w_lat_acc  = lat_valid && lat_ready;
   assign w_lat_nz   = (lat_addr != '0);
   assign w_head_vld = r_q_vld[r_head];

   // The queue drains whenever the primary path is idle.
   assign w_pop      = !w_pri_go && !w_empty;
   // Bypass only when nothing older is waiting, so ordering is preserved.
   assign w_bypass   = !w_pri_go && w_empty && w_lat_acc && w_lat_nz;
   // An accepted result whose register is overwritten by the primary path in
   // the same cycle is already stale, so it is dropped instead of queued.
   assign w_push     = w_lat_acc && w_lat_nz && !w_bypass &&
                       !(w_pri_go && (pri_addr == lat_addr));

   // ---------------------------------------------------------------------------
   // Per-entry address compares: WAW squash and hazard query
   // ---------------------------------------------------------------------------
   for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      assign w_squash[i] = w_pri_go && (r_q_addr[i] == pri_addr);
      // Valid bits are cleared on pop, so free slots never report a hit.
      assign w_hit[i]    = r_q_vld[i] && (r_q_addr[i] == chk_addr);
   end

   assign chk_pending = (chk_addr != '0) && (|w_hit);

   // ---------------------------------------------------------------------------
   // Write-port source selection
   // ---------------------------------------------------------------------------
   always_comb begin
      w_sel_we   = 1'b0;
      w_sel_upd  = 1'b0;
      w_sel_addr = pri_addr;
      w_sel_data = pri_data;
      if (w_pri_go) begin
         w_sel_we  = 1'b1;
         w_sel_upd = 1'b1;
      end else if (w_pop) begin
         // A squashed head still uses its slot this cycle, but it writes
         // nothing and the port keeps its last address/data.
         w_sel_we   = w_head_vld;
         w_sel_upd  = w_head_vld;
         w_sel_addr = r_q_addr[r_head];
         w_sel_data = r_q_data[r_head];
      end else if (w_bypass) begin
         w_sel_we   = 1'b1;
         w_sel_upd  = 1'b1;
         w_sel_addr = lat_addr;
         w_sel_data = lat_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rf_we    <= 1'b0;
         r_rf_waddr <= '0;
         r_rf_wdata <= '0;
      end else begin
         r_rf_we <= w_sel_we;
         if (w_sel_upd) begin
            r_rf_waddr <= w_sel_addr;
            r_rf_wdata <= w_sel_data;
         end
      end
   end

   assign rf_we    = r_rf_we;
   assign rf_waddr = r_rf_waddr;
   assign rf_wdata = r_rf_wdata;

   // ---------------------------------------------------------------------------
   // Queue control: pointers, occupancy, entry valid bits
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_q_vld <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_squash[i]) r_q_vld[i] <= 1'b0;
         end
         // Pop and push never address the same slot: a pop needs a non-empty
         // queue and a push needs a non-full one, so head != tail whenever
         // both happen.
         if (w_pop) begin
            r_q_vld[r_head] <= 1'b0;
            r_head          <= r_head + PTR_W'(1);
         end
         if (w_push) begin
            r_q_vld[r_tail] <= 1'b1;
            r_tail          <= r_tail + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Payload storage does not need a reset; the valid bits qualify it.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_addr[r_tail] <= lat_addr;
         r_q_data[r_tail] <= lat_data;
      end
   end

   assign q_count = r_count;

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
module tb_regfile_writeback_arbiter;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          pri_valid;
   logic [AW-1:0] pri_addr;
   logic [DW-1:0] pri_data;
   logic          lat_valid;
   logic          lat_ready;
   logic [AW-1:0] lat_addr;
   logic [DW-1:0] lat_data;
   logic          rf_we;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic [AW-1:0] chk_addr;
   logic          chk_pending;
   logic [2:0]    q_count;

   regfile_writeback_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .pri_valid(pri_valid), .pri_addr(pri_addr), .pri_data(pri_data),
      .lat_valid(lat_valid), .lat_ready(lat_ready),
      .lat_addr(lat_addr), .lat_data(lat_data),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .chk_addr(chk_addr), .chk_pending(chk_pending), .q_count(q_count)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      bit            v;
   } ent_t;

   ent_t          mq[$];
   bit            m_known = 0;
   bit            m_we;
   logic [AW-1:0] m_wa;
   logic [DW-1:0] m_wd;

   task automatic mdl_edge(input bit rs, input bit pv, input logic [AW-1:0] pa,
                           input logic [DW-1:0] pd, input bit lv,
                           input logic [AW-1:0] la, input logic [DW-1:0] ld,
                           input bit rdy);
      bit go, acc, byp;
      ent_t e;
      if (!rs) begin
         mq.delete();
         m_we = 0; m_wa = '0; m_wd = '0; m_known = 1;
         return;
      end
      go  = pv && (pa != 0);
      acc = lv && rdy;
      byp = 0;
      if (go) begin
         m_we = 1; m_wa = pa; m_wd = pd;
      end else if (mq.size() > 0) begin
         e = mq.pop_front();
         m_we = e.v;
         if (e.v) begin m_wa = e.a; m_wd = e.d; end
      end else if (acc && la != 0) begin
         byp = 1; m_we = 1; m_wa = la; m_wd = ld;
      end else begin
         m_we = 0;
      end
      if (go) foreach (mq[i]) if (mq[i].a == pa) mq[i].v = 0;
      if (acc && la != 0 && !byp && !(go && pa == la)) mq.push_back('{la, ld, 1'b1});
   endtask

   // values sampled by the last step
   bit         p_rdy, p_pend;
   logic [2:0] p_cnt;

   // One clock: drive, sample combinational outputs, advance model and DUT,
   // sample registered outputs. cmp enables model comparisons.
   task automatic step(input bit rs, input bit pv, input logic [AW-1:0] pa,
                       input logic [DW-1:0] pd, input bit lv,
                       input logic [AW-1:0] la, input logic [DW-1:0] ld,
                       input logic [AW-1:0] ca, input bit cmp);
      bit e_rdy, e_pend;
      rst_n = rs; pri_valid = pv; pri_addr = pa; pri_data = pd;
      lat_valid = lv; lat_addr = la; lat_data = ld; chk_addr = ca;
      #1;
      p_rdy = lat_ready; p_pend = chk_pending; p_cnt = q_count;
      e_rdy  = rs && (mq.size() != DEPTH);
      e_pend = 0;
      if (ca != 0) foreach (mq[i]) if (mq[i].v && mq[i].a == ca) e_pend = 1;
      if (cmp) begin
         chk("mdl lat_ready", 32'(p_rdy), 32'(e_rdy));
         if (m_known) begin
            chk("mdl chk_pending", 32'(p_pend), 32'(e_pend));
            chk("mdl q_count_pre", 32'(p_cnt), 32'(mq.size()));
         end
      end
      mdl_edge(rs, pv, pa, pd, lv, la, ld, e_rdy);
      @(posedge clk);
      #1;
      if (cmp) begin
         chk("mdl rf_we", 32'(rf_we), 32'(m_we));
         chk("mdl rf_waddr", 32'(rf_waddr), 32'(m_wa));
         chk("mdl rf_wdata", rf_wdata, m_wd);
         chk("mdl q_count", 32'(q_count), 32'(mq.size()));
      end
   endtask

   task automatic idle(input bit cmp);
      step(1, 0, '0, '0, 0, '0, '0, '0, cmp);
   endtask

   task automatic do_reset();
      step(0, 0, '0, '0, 0, '0, '0, '0, 1);
      step(0, 0, '0, '0, 0, '0, '0, '0, 1);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit            rs, pv;
      logic [AW-1:0] pa;
      logic [DW-1:0] pd;
      bit            lv;
      logic [AW-1:0] la;
      logic [DW-1:0] ld;
      logic [AW-1:0] ca;
      bit            rdy, pend;     // before the edge
      bit            we;            // after the edge
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      logic [2:0]    cnt;
   } vec_t;

   function automatic vec_t mk(int pv, int pa, int pd, int lv, int la, int ld, int ca,
                               int rdy, int pend, int we, int wa, int wd, int cnt);
      vec_t v;
      v.rs = 1; v.pv = pv[0]; v.pa = AW'(pa); v.pd = DW'(pd);
      v.lv = lv[0]; v.la = AW'(la); v.ld = DW'(ld); v.ca = AW'(ca);
      v.rdy = rdy[0]; v.pend = pend[0]; v.we = we[0];
      v.wa = AW'(wa); v.wd = DW'(wd); v.cnt = 3'(cnt);
      return v;
   endfunction

   vec_t tv[15];

   initial begin
      int acc;
      int nw;
      logic [AW-1:0] got_a[$];
      logic [DW-1:0] got_d[$];
      bit h_lv;
      logic [AW-1:0] h_la;
      logic [DW-1:0] h_ld;

      //            pv pa  pd      lv la  ld       ca  rdy pnd we wa  wd      cnt
      tv[0]  = mk(0, 0,  0,      1, 5,  'h1234, 0,  1,  0,  1, 5,  'h1234, 0); // bypass
      tv[1]  = mk(1, 3,  'h33,   1, 7,  'hA,    7,  1,  0,  1, 3,  'h33,   1); // queue r7
      tv[2]  = mk(1, 3,  'h34,   1, 8,  'hB,    7,  1,  1,  1, 3,  'h34,   2); // queue r8
      tv[3]  = mk(1, 3,  'h35,   0, 0,  0,      7,  1,  1,  1, 3,  'h35,   2);
      tv[4]  = mk(0, 0,  0,      0, 0,  0,      8,  1,  1,  1, 7,  'hA,    1); // drain r7
      tv[5]  = mk(0, 0,  0,      0, 0,  0,      8,  1,  1,  1, 8,  'hB,    0); // drain r8
      tv[6]  = mk(0, 0,  0,      0, 0,  0,      8,  1,  0,  0, 8,  'hB,    0);
      tv[7]  = mk(1, 4,  'h44,   1, 9,  'h11,   9,  1,  0,  1, 4,  'h44,   1); // queue r9
      tv[8]  = mk(1, 9,  'h22,   0, 0,  0,      9,  1,  1,  1, 9,  'h22,   1); // squash r9
      tv[9]  = mk(0, 0,  0,      0, 0,  0,      9,  1,  0,  0, 9,  'h22,   0); // dead pop
      tv[10] = mk(1, 6,  'h66,   1, 10, 'hAA,   10, 1,  0,  1, 6,  'h66,   1);
      tv[11] = mk(1, 0,  'hDEAD, 1, 0,  'hBEEF, 0,  1,  0,  1, 10, 'hAA,   0); // r0 pri/lat
      tv[12] = mk(0, 0,  0,      1, 0,  5,      10, 1,  0,  0, 10, 'hAA,   0); // lat r0
      tv[13] = mk(1, 12, 'hC1,   1, 12, 'hC2,   12, 1,  0,  1, 12, 'hC1,   0); // same-cycle drop
      tv[14] = mk(0, 0,  0,      0, 0,  0,      12, 1,  0,  0, 12, 'hC1,   0);

      // reset state
      do_reset();
      chk("reset rf_we", 32'(rf_we), 0);
      chk("reset rf_waddr", 32'(rf_waddr), 0);
      chk("reset rf_wdata", rf_wdata, 0);
      chk("reset q_count", 32'(q_count), 0);

      foreach (tv[i]) begin
         step(tv[i].rs, tv[i].pv, tv[i].pa, tv[i].pd, tv[i].lv, tv[i].la, tv[i].ld,
              tv[i].ca, 0);
         chk($sformatf("v%0d lat_ready", i), 32'(p_rdy), 32'(tv[i].rdy));
         chk($sformatf("v%0d chk_pending", i), 32'(p_pend), 32'(tv[i].pend));
         chk($sformatf("v%0d rf_we", i), 32'(rf_we), 32'(tv[i].we));
         chk($sformatf("v%0d rf_waddr", i), 32'(rf_waddr), 32'(tv[i].wa));
         chk($sformatf("v%0d rf_wdata", i), rf_wdata, tv[i].wd);
         chk($sformatf("v%0d q_count", i), 32'(q_count), 32'(tv[i].cnt));
      end

      // full / backpressure: primary busy for 6 cycles, lat offers r16..r21
      do_reset();
      acc = 0;
      for (int c = 0; c < 6; c++) begin
         step(1, 1, AW'(c + 1), DW'(c), 1, AW'(16 + acc), DW'(32'h100 + acc), '0, 1);
         if (c >= 4) chk($sformatf("full c%0d lat_ready", c), 32'(p_rdy), 0);
         if (p_rdy) acc++;
      end
      chk("full accepted", 32'(acc), 4);
      chk("full q_count", 32'(q_count), 4);
      nw = 0;
      for (int c = 0; c < 20 && nw < 6; c++) begin
         if (acc < 6) step(1, 0, '0, '0, 1, AW'(16 + acc), DW'(32'h100 + acc), '0, 1);
         else idle(1);
         if (acc < 6 && p_rdy) acc++;
         if (rf_we) begin got_a.push_back(rf_waddr); got_d.push_back(rf_wdata); nw++; end
      end
      chk("full drain count", 32'(nw), 6);
      for (int i = 0; i < 6 && i < got_a.size(); i++) begin
         chk($sformatf("full order%0d addr", i), 32'(got_a[i]), 32'(16 + i));
         chk($sformatf("full order%0d data", i), got_d[i], 32'h100 + i);
      end

      // reset mid-operation with 3 queued entries
      do_reset();
      for (int c = 0; c < 3; c++)
         step(1, 1, AW'(1), DW'(c), 1, AW'(20 + c), DW'(c + 7), '0, 1);
      chk("rst pre q_count", 32'(q_count), 3);
      step(0, 0, '0, '0, 1, AW'(23), DW'(9), '0, 1);
      chk("rst lat_ready low", 32'(p_rdy), 0);
      chk("rst q_count", 32'(q_count), 0);
      chk("rst rf_we", 32'(rf_we), 0);
      rst_n = 1'b0; #1;
      chk("rst held lat_ready", 32'(lat_ready), 0);
      idle(1);
      chk("rst release lat_ready", 32'(p_rdy), 1);
      chk("rst release rf_we", 32'(rf_we), 0);

      // randomized traffic against the model; small address range for collisions
      h_lv = 0; h_la = '0; h_ld = '0;
      for (int c = 0; c < 1500; c++) begin
         bit rs, pv;
         logic [AW-1:0] pa, ca;
         logic [DW-1:0] pd;
         if (!h_lv) begin
            h_lv = ($urandom_range(0, 99) < 60);
            h_la = AW'($urandom_range(0, 7));
            h_ld = $urandom;
         end
         rs = ($urandom_range(0, 199) != 0);
         pv = ($urandom_range(0, 99) < 55);
         pa = AW'($urandom_range(0, 7));
         pd = $urandom;
         ca = AW'($urandom_range(0, 7));
         step(rs, pv, pa, pd, h_lv, h_la, h_ld, ca, 1);
         if (h_lv && p_rdy) h_lv = 0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", n_chk, n_fail);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/regfile_writeback_arbiter.md
Name: regfile_writeback_arbiter

Overview:
- Write-side front end for the 32x32 register file: merges two result producers onto the single register-file write port.
- Producers: the primary pipeline result path (ALU/load, highest priority, no backpressure) and the long-latency unit (mul/div, valid/ready).
- Long-latency results wait in a small queue while the primary path owns the port.
- Enforces the r0 write discard and WAW ordering, and exposes a pending-write query for hazard logic.

Parameters:
- DATA_W, 32, write data width
- ADDR_W, 5, register address width
- DEPTH, 4, long-latency result queue entries (power of 2, >=2)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- pri_valid  in  1  primary result valid this cycle
- pri_addr  in  ADDR_W  primary destination register
- pri_data  in  DATA_W  primary result
- lat_valid  in  1  long-latency result offered
- lat_ready  out  1  arbiter accepts long-latency result
- lat_addr  in  ADDR_W  long-latency destination register
- lat_data  in  DATA_W  long-latency result
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  ADDR_W  register-file write address (registered)
- rf_wdata  out  DATA_W  register-file write data (registered)
- chk_addr  in  ADDR_W  hazard query address
- chk_pending  out  1  chk_addr has a queued, unsquashed write
- q_count  out  clog2(DEPTH)+1  current queue occupancy

Behaviour:
- Reset (rst_n=0 at clk edge): rf_we=0, rf_waddr=0, rf_wdata=0, queue emptied, q_count=0, all entry valid bits cleared. lat_ready=0 while rst_n=0.
- Definitions:
  - pri_go = pri_valid && pri_addr!=0. A primary write to r0 is ignored entirely.
  - lat_acc = lat_valid && lat_ready.
  - lat_ready = rst_n && (q_count != DEPTH). It is computed from registered occupancy and does not rise on a same-cycle pop.
- Output selection, one-cycle latency (rf_* are updated at the edge following the selection cycle):
  1. If pri_go: write pri_addr/pri_data.
  2. Else, if queue non-empty: pop the head entry. If the head is valid, write its addr/data. If it is squashed, rf_we=0 that cycle.
  3. Else, if lat_acc && lat_addr!=0: bypass, writing lat_addr/lat_data directly; nothing is enqueued.
  4. Else rf_we=0. rf_waddr/rf_wdata hold their last values.
- Enqueue:
  - An accepted lat result is pushed at the tail, with valid=1, unless one of the following holds:
    - it bypassed (rule 3);
    - lat_addr==0: accepted and dropped;
    - pri_go && pri_addr==lat_addr in the same cycle: accepted and dropped, because the primary result is newer.
  - Push and pop in the same cycle is allowed; q_count stays unchanged.
- WAW squash: when pri_go, every queued entry with addr==pri_addr has its valid bit cleared at that edge. Squashed entries still occupy a slot until popped.
- chk_pending: combinational OR over queued entries of (valid && addr==chk_addr). It is forced to 0 for chk_addr==0.
- Pointers wrap modulo DEPTH. Occupancy never exceeds DEPTH; a push into a full queue cannot occur because lat_ready=0.
- Reset mid-operation: queued results are lost. rf_we deasserts at the reset edge, so no partial write occurs.
- Writes reach the register file strictly in selection order. A queued entry is never written after a newer primary write to the same register.

Test Plan:
- Bypass: idle queue, lat_valid=1 addr=5 data=0x1234 -> next cycle rf_we=1, waddr=5, wdata=0x1234; q_count stays 0.
- Priority and queue: pri writes r3 for 3 cycles while lat offers r7=0xA, r8=0xB.
  - During those cycles: q_count reaches 2; chk_pending=1 for chk_addr=7.
  - After primary stops: r7 written, then r8 on consecutive cycles.
- Full/backpressure, DEPTH=4: pri_valid held high with distinct addrs, lat offers 6 results.
  - lat_ready drops after 4 are accepted.
  - Stalled results are accepted after the pops, and FIFO order is preserved.
- WAW squash: queue holds r9=0x11; pri writes r9=0x22.
  - Next pop gives rf_we=0, so the final r9 stays 0x22.
  - chk_pending for r9 goes to 0 right after the squash edge.
- r0 discard: pri to r0 with queue non-empty -> the queue pops that cycle instead. lat to r0 -> accepted, q_count unchanged, rf_we=0.
- Reset: rst_n=0 with 3 queued entries -> next cycle q_count=0, rf_we=0, lat_ready=0. After release, lat_ready=1.
